// File: rtl/instr_exec_pkg.sv
// instr_exec_pkg: shared types and the single-cycle ALU used by instr_exec_stage.
package instr_exec_pkg;

    typedef struct packed {
        logic [15:0]        opcode;
        logic signed [31:0] i0;
        logic signed [31:0] i1;
    } instruction_word_t;

    typedef enum logic [15:0] {
        OP_NOP = 16'h0000,
        OP_ADD = 16'h0001,
        OP_SUB = 16'h0002,
        OP_AND = 16'h0003,
        OP_OR  = 16'h0004,
        OP_XOR = 16'h0005,
        OP_MUL = 16'h0006
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULW = 2'd1,
        ST_HOLD = 2'd2
    } exec_state_t;

    typedef struct packed {
        logic [31:0] result;
        logic        ovf;
        logic        illegal;
    } alu_out_t;

    // Single-cycle ops; MUL is produced by the multi-cycle path in the top.
    function automatic alu_out_t alu_eval(input instruction_word_t w);
        alu_out_t    r;
        logic [31:0] sum;
        // NOTE: every local gets a value before the case so no path leaves it unassigned.
        r   = '0;
        sum = '0;
        case (w.opcode)
            OP_NOP: r.result = '0;
            OP_ADD: begin
                sum      = w.i0 + w.i1;
                r.result = sum;
                r.ovf    = (w.i0[31] == w.i1[31]) && (sum[31] != w.i0[31]);
            end
            OP_SUB: begin
                sum      = w.i0 - w.i1;
                r.result = sum;
                r.ovf    = (w.i0[31] != w.i1[31]) && (sum[31] != w.i0[31]);
            end
            OP_AND:  r.result = w.i0 & w.i1;
            OP_OR:   r.result = w.i0 | w.i1;
            OP_XOR:  r.result = w.i0 ^ w.i1;
            OP_MUL:  r.result = '0;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: DEPTH-entry synchronous FIFO; a push while full is dropped even if a pop occurs.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 80
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array: written on push only.
    // NOTE: the data array is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_exec_stage.sv
// instr_exec_stage: buffers instruction words in a FIFO, executes them and holds a registered result.
// Optional macro EXEC_STATS_EN adds handshake counters exec_count and illegal_count.
module instr_exec_stage
    import instr_exec_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  instruction_word_t          in_word,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [15:0]                out_opcode,
    output logic                       out_ovf,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     fifo_count
`ifdef EXEC_STATS_EN
    ,
    output logic [15:0]                exec_count,
    output logic [15:0]                illegal_count
`endif
);
    localparam int CW = $clog2(MUL_CYCLES + 1);

    instruction_word_t  head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    alu_out_t           alu;
    exec_state_t        state;
    logic [CW-1:0]      mul_cnt;
    logic signed [31:0] mul_a;
    logic signed [31:0] mul_b;
    logic signed [63:0] product;
    logic               mul_ovf;

    assign in_ready = !fifo_full;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(instruction_word_t))
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (in_valid),
        .wr_data (in_word),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A word is issued from IDLE, or from HOLD in the same edge the held result is taken.
    assign pop = !fifo_empty && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
    assign alu = alu_eval(head);

    // Multiplier works on operands captured at issue, so in_word changes cannot disturb it.
    assign product = mul_a * mul_b;
    assign mul_ovf = (product != {{32{product[31]}}, product[31:0]});

    // Issue / multiply-wait / hold state machine with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_opcode  <= '0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
            mul_cnt     <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (pop) begin
                        if (head.opcode == OP_MUL) begin
                            mul_a     <= head.i0;
                            mul_b     <= head.i1;
                            mul_cnt   <= CW'(MUL_CYCLES);
                            out_valid <= 1'b0;
                            state     <= ST_MULW;
                        end else begin
                            out_result  <= alu.result;
                            out_opcode  <= head.opcode;
                            out_ovf     <= alu.ovf;
                            out_illegal <= alu.illegal;
                            out_valid   <= 1'b1;
                            state       <= ST_HOLD;
                        end
                    end else if ((state == ST_HOLD) && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_MULW: begin
                    mul_cnt <= mul_cnt - 1'b1;
                    if (mul_cnt == CW'(1)) begin
                        out_result  <= product[31:0];
                        out_opcode  <= OP_MUL;
                        out_ovf     <= mul_ovf;
                        out_illegal <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef EXEC_STATS_EN
    // Count completed output handshakes and the illegal ones among them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exec_count    <= '0;
            illegal_count <= '0;
        end else if (out_valid && out_ready) begin
            exec_count <= exec_count + 16'd1;
            if (out_illegal) illegal_count <= illegal_count + 16'd1;
        end
    end
`endif

endmodule
